// File: rtl/pulse_catcher_if.sv
// Pulse catcher bus: the pulse line, acknowledge/clear controls and the
// captured-event status. The master drives the line and controls; the
// catcher (slave) reports strobe, pending, missed and the event count.
interface pulse_catcher_if #(
    parameter int CNT_W = 8
);
    logic             in_i;
    logic             ack_i;
    logic             clr_missed_i;
    logic             strobe_o;
    logic             pending_o;
    logic             missed_o;
    logic [CNT_W-1:0] count_o;

    modport master (
        output in_i, ack_i, clr_missed_i,
        input  strobe_o, pending_o, missed_o, count_o
    );

    modport slave (
        input  in_i, ack_i, clr_missed_i,
        output strobe_o, pending_o, missed_o, count_o
    );
endinterface

// File: rtl/pulse_catcher.sv
// pulse_catcher: synchronizes an active-low strobe line, captures one event
// per low period, holds it pending until acknowledged, counts events and
// flags events that arrive while an earlier one is still unacknowledged.
// Optional minimum-low-width filter: define PULSE_CATCHER_FILTER_EN.
module pulse_catcher #(
    parameter int CNT_W   = 8,
    parameter int MIN_LOW = 2
) (
    input  logic            clk,
    input  logic            reset,
    pulse_catcher_if.slave  bus
);

    // MIN_LOW must fit the 4-bit low-width counter and be at least one sample.
    if (MIN_LOW < 1 || MIN_LOW > 15) begin : g_min_low_range
        $error("pulse_catcher: MIN_LOW must be within 1..15");
    end

`ifdef PULSE_CATCHER_FILTER_EN
    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        ARMED     = 2'd1,
        QUAL      = 2'd2
    } state_e;

    localparam logic [3:0] MIN_LOW_W = 4'(MIN_LOW);

    logic [3:0] low_cnt_q, low_cnt_d;
    logic [3:0] low_cnt_inc;
`else
    typedef enum logic {
        WAIT_HIGH = 1'b0,
        ARMED     = 1'b1
    } state_e;
`endif

    state_e           state_q, state_d;
    logic             s1_q, s2_q;
    logic             strobe_q, strobe_d;
    logic             pending_q, pending_d;
    logic             missed_q, missed_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             capture;

    // Two-flop synchronizer; the line idles high, so reset loads ones.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= bus.in_i;
            s2_q <= s1_q;
        end
    end

    // State, event status and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= WAIT_HIGH;
            strobe_q  <= 1'b0;
            pending_q <= 1'b0;
            missed_q  <= 1'b0;
            count_q   <= '0;
`ifdef PULSE_CATCHER_FILTER_EN
            low_cnt_q <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            pending_q <= pending_d;
            missed_q  <= missed_d;
            count_q   <= count_d;
`ifdef PULSE_CATCHER_FILTER_EN
            low_cnt_q <= low_cnt_d;
`endif
        end
    end

`ifdef PULSE_CATCHER_FILTER_EN
    assign low_cnt_inc = low_cnt_q + 4'd1;
`endif

    // Edge detection / qualification FSM and the capture side effects.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        capture   = 1'b0;
        strobe_d  = 1'b0;
        pending_d = pending_q;
        missed_d  = missed_q;
        count_d   = count_q;
`ifdef PULSE_CATCHER_FILTER_EN
        low_cnt_d = low_cnt_q;
`endif

        case (state_q)
            // Line must be seen high before a falling edge can count.
            WAIT_HIGH: begin
                if (s2_q) state_d = ARMED;
            end
            ARMED: begin
                if (!s2_q) begin
`ifdef PULSE_CATCHER_FILTER_EN
                    if (MIN_LOW > 1) begin
                        state_d   = QUAL;
                        low_cnt_d = 4'd1;
                    end else begin
                        capture = 1'b1;
                        state_d = WAIT_HIGH;
                    end
`else
                    capture = 1'b1;
                    state_d = WAIT_HIGH;
`endif
                end
            end
`ifdef PULSE_CATCHER_FILTER_EN
            // Count consecutive low samples; a high sample first is a glitch.
            QUAL: begin
                if (!s2_q) begin
                    low_cnt_d = low_cnt_inc;
                    if (low_cnt_inc == MIN_LOW_W) begin
                        capture = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    low_cnt_d = 4'd0;
                    state_d   = ARMED;
                end
            end
`endif
            default: state_d = WAIT_HIGH;
        endcase

        if (bus.ack_i)        pending_d = 1'b0;
        if (bus.clr_missed_i) missed_d  = 1'b0;

        // A capture overrides ack (new event replaces the acked one) and
        // overrides clr_missed when it is itself a missed event.
        if (capture) begin
            strobe_d  = 1'b1;
            pending_d = 1'b1;
            count_d   = count_q + 1'b1;
            if (pending_q && !bus.ack_i) missed_d = 1'b1;
        end
    end

    assign bus.strobe_o  = strobe_q;
    assign bus.pending_o = pending_q;
    assign bus.missed_o  = missed_q;
    assign bus.count_o   = count_q;

endmodule

// File: tb/tb_pulse_catcher.sv
// Self-checking bench for pulse_catcher. A behavioural model tracks the
// synchronized line as a two-sample delay and declares an event whenever a
// low run reaches the qualifying length.
module tb_pulse_catcher;

    localparam int CNT_W   = 8;
    localparam int MIN_LOW = 3;
`ifdef PULSE_CATCHER_FILTER_EN
    localparam int REQ = MIN_LOW;
`else
    localparam int REQ = 1;
`endif
    localparam int CNT_MOD = 1 << CNT_W;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pulse_catcher_if #(.CNT_W(CNT_W)) bus ();

    pulse_catcher #(.CNT_W(CNT_W), .MIN_LOW(MIN_LOW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic m_pipe[$];
    int   m_run;
    logic m_strobe, m_pending, m_missed;
    int   m_count;
    int   strobes_seen;

    task automatic model_step(input logic rst_n_v, input logic in_v,
                              input logic ack_v, input logic clr_v);
        logic s;
        logic ev;
        if (!rst_n_v) begin
            m_pipe    = '{1'b1, 1'b1};
            m_run     = 0;
            m_strobe  = 1'b0;
            m_pending = 1'b0;
            m_missed  = 1'b0;
            m_count   = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(in_v);
            if (!s) m_run++;
            else    m_run = 0;
            ev = !s && (m_run == REQ);
            if (ev) begin
                if (m_pending && !ack_v) m_missed = 1'b1;
                else if (clr_v)          m_missed = 1'b0;
                m_pending = 1'b1;
                m_count   = (m_count + 1) % CNT_MOD;
            end else begin
                if (ack_v) m_pending = 1'b0;
                if (clr_v) m_missed  = 1'b0;
            end
            m_strobe = ev;
        end
    endtask

    // One clock: drive on negedge, model on posedge, outputs settle at +1.
    task automatic tick(input logic rst_n_v, input logic in_v,
                        input logic ack_v, input logic clr_v);
        @(negedge clk);
        reset            = rst_n_v;
        bus.in_i         = in_v;
        bus.ack_i        = ack_v;
        bus.clr_missed_i = clr_v;
        @(posedge clk);
        model_step(rst_n_v, in_v, ack_v, clr_v);
        #1;
        if (bus.strobe_o === 1'b1) strobes_seen++;
    endtask

    // Low for low_len cycles then high for high_len; optional ack on last high.
    task automatic pulse(input int low_len, input int high_len, input logic ack_last);
        for (int i = 0; i < low_len; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < high_len; i++)
            tick(1'b1, 1'b1, ack_last && (i == high_len - 1), 1'b0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        strobes_seen = 0;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)  tick(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.strobe_o, bus.pending_o, bus.missed_o} !== 3'b000 || bus.count_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got s/p/m=%b%b%b count=%0d, want 000 count=0",
                     bus.strobe_o, bus.pending_o, bus.missed_o, bus.count_o);
        end
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (strobes_seen != 0 || bus.count_o !== 8'd0 || bus.pending_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: strobes=%0d count=%0d pending=%b, want 0 0 0",
                     strobes_seen, bus.count_o, bus.pending_o);
        end
    endtask

    task automatic test_single_pulse();
        int seen_at = -1;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, (i < REQ) ? 1'b0 : 1'b1, (i == 5), 1'b0);
            if (bus.strobe_o === 1'b1) begin
                n++;
                seen_at = i;
            end
            if (i == REQ + 1) begin
                checks++;
                if (bus.pending_o !== 1'b1 || bus.count_o !== 8'd1) begin
                    errors++;
                    $display("FAIL single_capture: pending=%b count=%0d, want 1 1",
                             bus.pending_o, bus.count_o);
                end
            end
        end
        checks++;
        if (n != 1 || seen_at != REQ + 1) begin
            errors++;
            $display("FAIL single_latency: strobes=%0d at=%0d, want 1 at %0d", n, seen_at, REQ + 1);
        end
        checks++;
        if (bus.pending_o !== 1'b0 || bus.missed_o !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: pending=%b missed=%b, want 0 0", bus.pending_o, bus.missed_o);
        end
    endtask

    task automatic test_short_pulse();
        logic [CNT_W-1:0] base;
        base = bus.count_o;
        strobes_seen = 0;
`ifdef PULSE_CATCHER_FILTER_EN
        pulse(REQ - 1, 6, 1'b0);
        checks++;
        if (strobes_seen != 0 || bus.count_o !== base) begin
            errors++;
            $display("FAIL short_reject: strobes=%0d count=%0d, want 0 %0d",
                     strobes_seen, bus.count_o, base);
        end
        pulse(REQ, 6, 1'b1);
        checks++;
        if (strobes_seen != 1 || bus.count_o !== base + 8'd1) begin
            errors++;
            $display("FAIL exact_width: strobes=%0d count=%0d, want 1 %0d",
                     strobes_seen, bus.count_o, base + 8'd1);
        end
`else
        pulse(1, 6, 1'b1);
        checks++;
        if (strobes_seen != 1 || bus.count_o !== base + 8'd1) begin
            errors++;
            $display("FAIL one_cycle_catch: strobes=%0d count=%0d, want 1 %0d",
                     strobes_seen, bus.count_o, base + 8'd1);
        end
`endif
    endtask

    task automatic test_missed();
        do_reset();
        pulse(REQ, 4, 1'b0);
        pulse(REQ, 4, 1'b0);
        checks++;
        if (bus.count_o !== 8'd2 || bus.pending_o !== 1'b1 || bus.missed_o !== 1'b1) begin
            errors++;
            $display("FAIL missed_set: count=%0d pending=%b missed=%b, want 2 1 1",
                     bus.count_o, bus.pending_o, bus.missed_o);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.missed_o !== 1'b0 || bus.pending_o !== 1'b1) begin
            errors++;
            $display("FAIL missed_clear: missed=%b pending=%b, want 0 1", bus.missed_o, bus.pending_o);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_ack_collision();
        do_reset();
        pulse(REQ, 4, 1'b0);
        // Second pulse with ack landing on the capture edge.
        for (int i = 0; i < REQ + 2; i++)
            tick(1'b1, (i < REQ) ? 1'b0 : 1'b1, (i == REQ + 1), 1'b0);
        checks++;
        if (bus.strobe_o !== 1'b1 || bus.pending_o !== 1'b1 || bus.missed_o !== 1'b0
            || bus.count_o !== 8'd2) begin
            errors++;
            $display("FAIL ack_collision: s/p/m=%b%b%b count=%0d, want 110 count=2",
                     bus.strobe_o, bus.pending_o, bus.missed_o, bus.count_o);
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        // Third pulse, unacked, with clr_missed on the capture edge: set wins.
        for (int i = 0; i < REQ + 2; i++)
            tick(1'b1, (i < REQ) ? 1'b0 : 1'b1, 1'b0, (i == REQ + 1));
        checks++;
        if (bus.missed_o !== 1'b1 || bus.count_o !== 8'd3) begin
            errors++;
            $display("FAIL clr_collision: missed=%b count=%0d, want 1 3", bus.missed_o, bus.count_o);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        strobes_seen = 0;
        for (int p = 0; p < CNT_MOD; p++) pulse(REQ, 4, 1'b1);
        checks++;
        if (strobes_seen != CNT_MOD || bus.count_o !== 8'd0 || bus.missed_o !== 1'b0) begin
            errors++;
            $display("FAIL count_wrap: strobes=%0d count=%0d missed=%b, want %0d 0 0",
                     strobes_seen, bus.count_o, bus.missed_o, CNT_MOD);
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        pulse(REQ, 4, 1'b0);
        strobes_seen = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.strobe_o, bus.pending_o, bus.missed_o} !== 3'b000 || bus.count_o !== 8'd0) begin
            errors++;
            $display("FAIL mid_pulse_reset: s/p/m=%b%b%b count=%0d, want 000 count=0",
                     bus.strobe_o, bus.pending_o, bus.missed_o, bus.count_o);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (strobes_seen != 0 || bus.count_o !== 8'd0 || bus.pending_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_pulse_discard: strobes=%0d count=%0d pending=%b, want 0 0 0",
                     strobes_seen, bus.count_o, bus.pending_o);
        end
    endtask

    task automatic test_random();
        logic level = 1'b1;
        int   run_left = 0;
        logic rst_n_v, ack_v, clr_v;
        int   bad = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (run_left == 0) begin
                level    = ~level;
                run_left = $urandom_range(1, 5);
            end
            run_left--;
            rst_n_v = ($urandom_range(0, 199) != 0);
            ack_v   = ($urandom_range(0, 5) == 0);
            clr_v   = ($urandom_range(0, 11) == 0);
            tick(rst_n_v, level, ack_v, clr_v);
            checks++;
            if (bus.strobe_o !== m_strobe || bus.pending_o !== m_pending
                || bus.missed_o !== m_missed || bus.count_o !== CNT_W'(m_count)) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle %0d: s/p/m=%b%b%b count=%0d, want %b%b%b count=%0d",
                             i, bus.strobe_o, bus.pending_o, bus.missed_o, bus.count_o,
                             m_strobe, m_pending, m_missed, m_count);
            end
        end
    endtask

    initial begin
        reset            = 1'b0;
        bus.in_i         = 1'b1;
        bus.ack_i        = 1'b0;
        bus.clr_missed_i = 1'b0;
        model_step(1'b0, 1'b1, 1'b0, 1'b0);
        test_reset();
        test_single_pulse();
        test_short_pulse();
        test_missed();
        test_ack_collision();
        test_wrap();
        test_reset_mid_pulse();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
